// File: rtl/fractcam_top.sv
// SRL32-based fractured CAM: DEPTH entries of WIDTH-bit keys, 2-stage search and serial group update.
// Optional FRACTCAM_OUT_REG_EN adds an output register after the OR-reduce (search latency 3).
module fractcam_top #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 160,
  localparam int GW   = $clog2(DEPTH / 8)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sk,
  input  logic             wr,
  input  logic [GW-1:0]    we_sel,
  output logic             match_reduced
);

  localparam int NS = WIDTH / 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GUARD
  } state_t;

  state_t           state;
  logic             wr_q;
  logic [WIDTH-1:0] key_l;
  logic [GW-1:0]    grp;
  logic [2:0]       ei;
  logic [4:0]       c;

  logic             trigger;
  logic             busy_nxt;
  logic [GW+2:0]    wr_ent;
  logic [NS-1:0][31:0] shift_word;
  logic [DEPTH-1:0] ent_hit;
  logic [DEPTH-1:0] ent_q;

  // NOTE: the SRL array has no reset branch on purpose: SRL primitives cannot be reset,
  // and the content must survive a reset; the declaration initialiser is the power-up INIT.
  logic [NS-1:0][31:0] srl [DEPTH] = '{default: '0};

  assign trigger = (state == IDLE) && wr && !wr_q;
  assign wr_ent  = {grp, ei};

  // Next-cycle busy flag, so the output is blanked on the very edge the update starts.
  always_comb begin
    busy_nxt = 1'b0;
    case (state)
      IDLE:    busy_nxt = trigger;
      SHIFT:   busy_nxt = 1'b1;
      GUARD:   busy_nxt = (c != 5'd31);
      default: busy_nxt = 1'b0;
    endcase
  end

  // Bit entering each SRL of the entry being written: 1 only when the slice equals 31-c,
  // so after 32 shifts bit a is set exactly at a == slice value.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      shift_word[s] = {srl[wr_ent][s][30:0], (key_l[5*s +: 5] == (5'd31 - c))};
    end
  end

  always_ff @(posedge clk) begin
    if (reset && state == SHIFT) begin
      srl[wr_ent] <= shift_word;
    end
  end

  // NOTE: always_comb drives every output with a default first so no latch is inferred.
  always_comb begin
    ent_hit = '1;
    for (int e = 0; e < DEPTH; e++) begin
      for (int s = 0; s < NS; s++) begin
        ent_hit[e] = ent_hit[e] & srl[e][s][sk[5*s +: 5]];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      wr_q  <= 1'b0;
      key_l <= '0;
      grp   <= '0;
      ei    <= '0;
      c     <= '0;
    end else begin
      wr_q <= wr;
      case (state)
        IDLE: begin
          if (trigger) begin
            key_l <= sk;
            grp   <= we_sel;
            ei    <= '0;
            c     <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          c <= c + 5'd1;
          if (c == 5'd31) begin
            ei <= ei + 3'd1;
            if (ei == 3'd7) state <= GUARD;
          end
        end
        GUARD: begin
          c <= c + 5'd1;
          if (c == 5'd31) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FRACTCAM_OUT_REG_EN
  logic or_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ent_q         <= '0;
      or_q          <= 1'b0;
      match_reduced <= 1'b0;
    end else begin
      ent_q         <= ent_hit;
      or_q          <= |ent_q;
      match_reduced <= !busy_nxt && or_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      ent_q         <= '0;
      match_reduced <= 1'b0;
    end else begin
      ent_q         <= ent_hit;
      match_reduced <= !busy_nxt && (|ent_q);
    end
  end
`endif

endmodule

// File: tb/tb_fractcam_top.sv
// Directed self-checking bench for fractcam_top: search, group update, masking, reset abort, wr hold.
module tb_fractcam_top;

  localparam int DEPTH = 1024;
  localparam int WIDTH = 160;
`ifdef FRACTCAM_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] sk = '0;
  logic             wr = 1'b0;
  logic [6:0]       we_sel = '0;
  logic             match_reduced;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] kq[$];
  logic             eq[$];

  fractcam_top #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .sk            (sk),
    .wr            (wr),
    .we_sel        (we_sel),
    .match_reduced (match_reduced)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Streams kq one key per cycle and checks each result LAT edges after its key.
  task automatic run_search(input string tag);
    for (int i = 0; i < kq.size() + LAT - 1; i++) begin
      if (i < kq.size()) sk = kq[i];
      tick(1);
      if (i >= LAT - 1) check($sformatf("%s[%0d]", tag, i - LAT + 1), match_reduced, eq[i - LAT + 1]);
    end
  endtask

  task automatic check_busy(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d]", tag, i), match_reduced, 1'b0);
      tick(1);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] k17_top;
    k17_top = 160'd17;
    k17_top[WIDTH-1] = 1'b1;

    tick(50);
    check("reset_out", match_reduced, 1'b0);
    reset = 1'b1;
    tick(2);

    // Empty CAM: nothing matches.
    kq = '{160'd0, 160'd3, 160'd20, 160'd30, 160'd17};
    eq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_search("empty");

    // Write key 17 into group 0, holding wr for the whole update.
    sk = 160'd17; we_sel = 7'd0; wr = 1'b1;
    tick(1);
    check_busy("upd0_busy", 288);
    wr = 1'b0;

    kq = '{160'd0, 160'd3, 160'd20, 160'd30, 160'd17, k17_top};
    eq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    run_search("after_upd0");

    we_sel = 7'd2;
    run_search("wesel_ignored");

    // Group 5 update aborted by reset after 100 shifts: entries 40..42 are complete.
    sk = 160'h3FF; we_sel = 7'd5; wr = 1'b1;
    tick(1);
    wr = 1'b0;
    check_busy("upd5_busy", 100);
    reset = 1'b0;
    tick(1);
    check("abort_reset_out", match_reduced, 1'b0);
    tick(1);
    check("abort_reset_hold", match_reduced, 1'b0);
    reset = 1'b1;
    tick(1);
    kq = '{160'd17, 160'h3FF, 160'd0, 160'h1FF};
    eq = '{1'b1, 1'b1, 1'b0, 1'b0};
    run_search("after_abort");

    // Long wr hold: exactly one update of group 1 with key 30.
    sk = 160'd30; we_sel = 7'd1; wr = 1'b1;
    tick(1);
    check_busy("upd1_busy", 288);
    kq = '{160'd30, 160'd17, 160'h3FF, 160'd0, 160'd30};
    eq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    run_search("hold_no_retrigger");
    sk = 160'd17;
    tick(300);
    check("hold_late", match_reduced, 1'b1);
    wr = 1'b0;
    kq = '{160'd30, 160'd17, 160'd20};
    eq = '{1'b1, 1'b1, 1'b0};
    run_search("after_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
